// File: rtl/regfile_wr_arbiter_if.sv
// Writeback requester channel for the register-file write-port arbiter.
// One instance per requester. The master (the writeback source) drives
// valid/rd/data and holds them stable until it sees ready. The slave
// (the arbiter) returns ready in the same cycle.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output rd, output data, input ready);
  modport slave  (input valid, input rd, input data, output ready);
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file's single write port
// between ALU writeback (req0) and load return (req1).
//
// - Grants are combinational, with at most one ready per cycle.
// - The write-port outputs are registered, so a transfer in cycle N
//   drives wr_en/wr_rd/wr_data in cycle N+1.
// - wr_count counts committed writes and saturates at all-ones.
//
// Optional build macro ZERO_REG_PROTECT_EN: a request that targets x0 is
// still accepted and still moves the pointer, but it never raises wr_en
// and is not counted.
module regfile_wr_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_wr_arbiter_if.slave      req0,
  regfile_wr_arbiter_if.slave      req1,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_rd,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     last_grant,
  output logic [CNT_W-1:0]         wr_count
);

  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic              next_en;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  // Pick the winner: a lone valid requester wins; under contention the
  // requester that did not win last time wins. Nothing is granted in reset.
  always_comb begin
    // NOTE: both grants get a default first so no path through this block infers a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0.valid && req1.valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0.valid;
        grant1 = req1.valid;
      end
    end
  end

  assign req0.ready = grant0;
  assign req1.ready = grant1;
  assign xfer       = grant0 | grant1;
  assign sel_rd     = grant1 ? req1.rd   : req0.rd;
  assign sel_data   = grant1 ? req1.data : req0.data;

`ifdef ZERO_REG_PROTECT_EN
  // A write to x0 is swallowed so the register stays constant.
  assign next_en = xfer && (sel_rd != '0);
`else
  assign next_en = xfer;
`endif

  // Register the granted write and advance the pointer and the commit counter.
  // The counter steps on the same edge that raises wr_en, so during a write
  // cycle it already includes that write.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it is sampled only on the clock edge like any other input.
    if (reset) begin
      wr_en      <= 1'b0;
      wr_rd      <= '0;
      wr_data    <= '0;
      last_grant <= 1'b1;
      wr_count   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here see the pre-edge values of the others.
      wr_en <= next_en;
      if (xfer) begin
        last_grant <= grant1;
        wr_rd      <= sel_rd;
        wr_data    <= sel_data;
      end
      if (next_en && (wr_count != '1)) begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter.
//
// - The DUT is built with CNT_W=4 so counter saturation is reachable in a
//   short run.
// - A behavioural model decides each cycle's winner from the arbitration
//   rules, and predicts the registered write port and the counter.
// - dut_regs mirrors the register file, fed from the DUT write port.
// - Compile with ZERO_REG_PROTECT_EN to check the protected-x0 variant.
module tb_regfile_wr_arbiter;
  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic              last_grant;
  logic [CNT_W-1:0]  wr_count;

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) req0 ();
  regfile_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) req1 ();

  regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .wr_en      (wr_en),
    .wr_rd      (wr_rd),
    .wr_data    (wr_data),
    .last_grant (last_grant),
    .wr_count   (wr_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit m_last;
  int m_count;
  int last_g;

  // Register file contents as written by the DUT's write port.
  logic [DATA_W-1:0] dut_regs [32];

  // Commit each write at the end of its wr_en cycle, like the real register file.
  always @(posedge clk) begin
    if (wr_en === 1'b1) dut_regs[wr_rd] <= wr_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Run one clock cycle with the inputs already driven. The step checks the
  // combinational ready lines mid-cycle, then checks the registered outputs
  // just after the edge. It returns the index of the model's winner, or -1.
  task automatic step(input bit rst, output int g);
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] d;
    bit en;
    reset = rst;
    #3;
    g = -1;
    if (!rst) begin
      if (req0.valid && req1.valid) g = m_last ? 0 : 1;
      else if (req0.valid)          g = 0;
      else if (req1.valid)          g = 1;
    end
    check("req0_ready", 64'(req0.ready), 64'(g == 0));
    check("req1_ready", 64'(req1.ready), 64'(g == 1));
    rd = (g == 1) ? req1.rd   : req0.rd;
    d  = (g == 1) ? req1.data : req0.data;
    @(posedge clk);
    #1;
    if (rst) begin
      m_last  = 1'b1;
      m_count = 0;
      check("rst_wr_en",   64'(wr_en),   64'd0);
      check("rst_wr_rd",   64'(wr_rd),   64'd0);
      check("rst_wr_data", 64'(wr_data), 64'd0);
    end else if (g >= 0) begin
      m_last = (g == 1);
      en = 1'b1;
`ifdef ZERO_REG_PROTECT_EN
      if (rd == '0) en = 1'b0;
`endif
      if (en && m_count < CNT_MAX) m_count++;
      check("wr_en", 64'(wr_en), 64'(en));
      if (en) begin
        check("wr_rd",   64'(wr_rd),   64'(rd));
        check("wr_data", 64'(wr_data), 64'(d));
      end
    end else begin
      check("idle_wr_en", 64'(wr_en), 64'd0);
    end
    check("last_grant", 64'(last_grant), 64'(m_last));
    check("wr_count",   64'(wr_count),   64'(m_count));
  endtask

  task automatic drive0(input bit v, input int rd, input logic [DATA_W-1:0] d);
    req0.valid = v;
    req0.rd    = ADDR_W'(rd);
    req0.data  = d;
  endtask

  task automatic drive1(input bit v, input int rd, input logic [DATA_W-1:0] d);
    req1.valid = v;
    req1.rd    = ADDR_W'(rd);
    req1.data  = d;
  endtask

  initial begin
    int g;
    m_last  = 1'b1;
    m_count = 0;
    reset   = 1'b1;
    drive0(1'b0, 0, '0);
    drive1(1'b0, 0, '0);

    // Reset held two cycles while req0 is already valid: no grant.
    drive0(1'b1, 9, 64'h99);
    step(1'b1, g);
    step(1'b1, g);
    // First cycle after release: req0 is accepted and written next cycle.
    step(1'b0, g);
    drive0(1'b0, 0, '0);
    step(1'b0, g);

    // req0 alone after a fresh reset: rd=10, data=32, count becomes 1.
    step(1'b1, g);
    drive0(1'b1, 10, 64'd32);
    step(1'b0, g);
    drive0(1'b0, 0, '0);
    step(1'b0, g);

    // Both valid for four cycles: grants alternate 0,1,0,1.
    step(1'b1, g);
    drive0(1'b1, 3, 64'd5);
    drive1(1'b1, 4, 64'd6);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, g);
      check("alt_grant", 64'(g), 64'(i % 2));
    end
    drive0(1'b0, 0, '0);
    drive1(1'b0, 0, '0);
    step(1'b0, g);

    // Both target rd=20 right after reset: req0 first, then req1, final 32.
    step(1'b1, g);
    drive0(1'b1, 20, 64'd21);
    drive1(1'b1, 20, 64'd32);
    step(1'b0, g);
    drive0(1'b0, 0, '0);
    step(1'b0, g);
    drive1(1'b0, 0, '0);
    step(1'b0, g);
    check("reg20_final", dut_regs[20], 64'd32);

    // req1 writes x0 with data 7. Only the protected build suppresses the write.
    drive1(1'b1, 0, 64'd7);
    step(1'b0, g);
    drive1(1'b0, 0, '0);
    step(1'b0, g);

    // Sixteen back-to-back req0 writes: a 4-bit counter stops at 15.
    step(1'b1, g);
    for (int i = 0; i < 16; i++) begin
      drive0(1'b1, i + 1, 64'(i * 3 + 1));
      step(1'b0, g);
    end
    drive0(1'b0, 0, '0);
    step(1'b0, g);
    check("count_saturated", 64'(wr_count), 64'(CNT_MAX));

    // Random traffic with occasional reset. A requester keeps its request
    // stable until it is accepted, then may present a new one.
    step(1'b1, g);
    for (int i = 0; i < 400; i++) begin
      bit rst;
      rst = ($urandom_range(0, 99) < 3);
      if (!req0.valid || last_g == 0)
        drive0(($urandom_range(0, 3) != 0), $urandom_range(0, 31), {$urandom, $urandom});
      if (!req1.valid || last_g == 1)
        drive1(($urandom_range(0, 3) != 0), $urandom_range(0, 31), {$urandom, $urandom});
      step(rst, g);
      last_g = g;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
